// File: rtl/unidir_bus_rx.sv
// unidir_bus_rx: receiving end of a unidirectional bus. Each rising edge of
// bus_en captures one bus_d word into a first-word-fall-through FIFO that
// drains through a valid/ready handshake. There is no return path to the
// transmitter, so words arriving at a full FIFO are dropped and flagged in
// the sticky ovf bit.
module unidir_bus_rx #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           bus_d,
    input  logic                       bus_en,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       ovf,
    input  logic                       ovf_clr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    // Registered state
    logic                 en_q,     en_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q,  count_d;
    logic                 ovf_q,    ovf_d;
    logic [WIDTH-1:0]     mem_q [DEPTH];

    // Per-cycle events
    logic strobe;
    logic push;
    logic pop;
    logic drop;

    // Status outputs come only from registered state: no path from the bus inputs.
    assign out_valid = (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign ovf       = ovf_q;
    assign out_data  = mem_q[rd_ptr_q];

    // Strobe detection, push/pop/drop decisions and next-state computation.
    always_comb begin
        strobe   = bus_en & ~en_q;
        pop      = out_valid & out_ready;
        push     = strobe & (~full | pop);
        drop     = strobe & full & ~pop;

        en_d     = bus_en;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // A drop in the same cycle as ovf_clr leaves the flag set.
        ovf_d    = drop | (ovf_q & ~ovf_clr);

        // Pointers are log2(DEPTH) bits, so they wrap modulo DEPTH for free.
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous reset; en_q resets high so a
    // bus_en level already high across reset does not count as a strobe.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its inputs regardless of block order.
        if (rst) begin
            en_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            en_q     <= en_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; count gates
        // out_valid, so stale contents are never presented as valid data.
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= bus_d;
        end
    end

endmodule

// File: doc/unidir_bus_rx.md
# unidir_bus_rx

Receiving end of the 4-bit unidirectional bus. It watches the bus data lines and the transmitter's enable strobe, and captures one word on every rising edge of the enable. Captured words go into a small first-word-fall-through FIFO, which drains through a valid/ready handshake to the downstream consumer. Overflow is reported by a sticky flag instead of backpressure, because the bus has no return path to the transmitter.

## Interface
- WIDTH, 4, bus data width in bits.
- DEPTH, 4, FIFO depth in words; must be a power of two and ≥ 2.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bus_d  input  WIDTH  bus data lines from the transmitter.
- bus_en  input  1  transmitter enable/strobe; a 0→1 transition marks one word.
- out_data  output  WIDTH  head-of-FIFO word; valid only while out_valid=1.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- count  output  $clog2(DEPTH+1)  number of words currently held.
- full  output  1  count == DEPTH.
- ovf  output  1  sticky flag: a strobed word was dropped.
- ovf_clr  input  1  clears ovf.

## Operation
- Reset values: en_q=1, write pointer=0, read pointer=0, count=0, ovf=0, out_valid=0, full=0. out_data is don't-care while out_valid=0.
- Edge detect: en_q registers bus_en every cycle. A strobe occurs when bus_en=1 and en_q=0.
- en_q resets to 1, so a bus_en level held high across reset produces no word. The line must go low and then high again.
- Capture: on a strobe cycle, bus_d is sampled in that same cycle.
- Push: a strobe pushes when full=0, or when full=1 and a pop occurs in the same cycle.
- Drop: a strobe with full=1 and no pop discards the word and sets ovf. FIFO contents and count do not change.
- Pop: occurs when out_valid=1 and out_ready=1; the read pointer advances.
- out_ready while out_valid=0 is ignored.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- On an empty FIFO, a push and a ready consumer in the same cycle produce no pop, because out_valid=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count is explicit, not derived from the pointers, and never exceeds DEPTH or underflows.
- out_data is combinational from mem[read pointer] (first-word fall-through).
- ovf_clr clears ovf. If a drop and ovf_clr occur in the same cycle, the set wins and ovf=1.
- Reset asserted mid-operation flushes all words and clears ovf on the next edge. No strobe is recognised in a reset cycle.

## Timing
- Capture latency: a word strobed in cycle N is visible with out_valid=1 in cycle N+1, provided the FIFO was empty.
- Throughput: one strobe at minimum every 2 cycles (bus_en 1 for one cycle, 0 for one cycle). The FIFO accepts one push and one pop per cycle.
- count, full and ovf update on the clock edge that ends the push/pop/drop cycle.
- out_data changes in the cycle after a pop, or after a push into an empty FIFO.
- Holding bus_en high for many cycles yields exactly one word.
- No combinational path exists from bus_d or bus_en to any output.
- out_valid depends only on registered state.

## Test plan
- Basic capture: after reset, drive bus_d=4'hA, bus_en 0→1, with out_ready=0. Required: out_valid=1 and out_data=4'hA next cycle, count=1. Holding bus_en high 10 more cycles leaves count=1.
- Order and wrap: strobe 4'h1, 4'h2, 4'h3, 4'h4, then pop all, then strobe 4'h5 and 4'h6. Required: full=1 after the 4th strobe, pops return 1,2,3,4, then 5,6 (pointer wrap), count returns to 0.
- Overflow: fill with 4'h1–4'h4, strobe 4'hF with out_ready=0. Required: ovf=1, count=4, subsequent pops return 1,2,3,4 with no 4'hF. Assert ovf_clr: ovf=0 next cycle. Assert ovf_clr in the same cycle as a new drop: ovf stays 1.
- Full with simultaneous pop: with the FIFO full and out_ready=1, strobe 4'h9. Required: no ovf, count stays 4, 4'h9 is the last word read.
- Reset: with count=3 and ovf=1, assert rst for one cycle while bus_en=1. Required: count=0, out_valid=0, ovf=0. Keeping bus_en high after reset captures nothing; bus_en 0→1 then captures the next word.
- Sweep: drive bus_d 0..15, each with bus_en low 2 cycles then high 2 cycles, with out_ready=1. Required: 16 words read in order 0..15, ovf never set.
